// File: rtl/register_file_mp.sv
// Multi-port register file: post-reset INIT sweep, two prioritised write ports and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto read ports and debug_reg.

module register_file_mp_rd_lane #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 32'hFFFF_FF91,
  parameter int                    ZERO_REG    = 1
) (
  input  logic [ADDR_WIDTH-1:0]                       idx,
  input  logic                                        run,
  input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]  regs,
  input  logic                                        fwd_en,
  input  logic [DATA_WIDTH-1:0]                       fwd_data,
  output logic [DATA_WIDTH-1:0]                       data
);
  // While INIT runs the array is only partly swept, so reads report the sweep value.
  always_comb begin
    data = regs[idx];
    if (ZERO_REG != 0 && idx == '0) data = '0;
    else if (!run)                  data = RESET_VALUE;
    else if (fwd_en)                data = fwd_data;
  end
endmodule

module register_file_mp #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    READ_PORTS  = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 32'hFFFF_FF91,
  parameter int                    ZERO_REG    = 1,
  parameter int                    DEBUG_INDEX = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_index,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_pending,
  input  logic                             wr0_enable,
  input  logic [ADDR_WIDTH-1:0]            wr0_index,
  input  logic [DATA_WIDTH-1:0]            wr0_data,
  input  logic                             wr1_enable,
  input  logic [ADDR_WIDTH-1:0]            wr1_index,
  input  logic [DATA_WIDTH-1:0]            wr1_data,
  input  logic                             reserve_enable,
  input  logic [ADDR_WIDTH-1:0]            reserve_index,
  output logic                             ready,
  output logic [DATA_WIDTH-1:0]            debug_reg
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LANES = READ_PORTS + 1;   // last lane serves debug_reg

  typedef enum logic {INIT, RUN} state_t;

  state_t                            state, state_nx;
  logic [ADDR_WIDTH-1:0]             cnt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  regs;
  logic [DEPTH-1:0]                  pending;
  logic                              run, wr0_go, wr1_go, rsv_go;

  function automatic logic writable(input logic [ADDR_WIDTH-1:0] i);
    return !(ZERO_REG != 0 && i == '0);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == INIT && cnt == {ADDR_WIDTH{1'b1}}) state_nx = RUN;
  end

  assign run    = (state == RUN);
  assign ready  = run;
  assign wr0_go = run && wr0_enable && writable(wr0_index);
  assign wr1_go = run && wr1_enable && writable(wr1_index);
  assign rsv_go = run && reserve_enable && writable(reserve_index);

  // Array has no reset; the sweep initialises it one entry per cycle. wr1 is applied last so it wins.
  always_ff @(posedge clk) begin
    if (!run) begin
      regs[cnt] <= RESET_VALUE;
    end else begin
      if (wr0_go) regs[wr0_index] <= wr0_data;
      if (wr1_go) regs[wr1_index] <= wr1_data;
    end
  end

  // Reserve is applied after the wr1 clear so a same-edge reserve leaves the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else if (run) begin
      if (wr1_go) pending[wr1_index]     <= 1'b0;
      if (rsv_go) pending[reserve_index] <= 1'b1;
    end
  end

  logic [LANES-1:0][ADDR_WIDTH-1:0] lane_idx;
  logic [LANES-1:0][DATA_WIDTH-1:0] lane_data;

  assign lane_idx[READ_PORTS] = ADDR_WIDTH'(DEBUG_INDEX);
  assign debug_reg            = lane_data[READ_PORTS];

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_port
    assign lane_idx[k]                         = read_index[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_data[k];
    assign read_pending[k]                     = run && pending[lane_idx[k]];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic                  fwd_en;
    logic [DATA_WIDTH-1:0] fwd_data;
`ifdef REGFILE_BYPASS_EN
    always_comb begin
      fwd_en   = 1'b0;
      fwd_data = wr0_data;
      if (wr0_go && wr0_index == lane_idx[k]) fwd_en = 1'b1;
      if (wr1_go && wr1_index == lane_idx[k]) begin
        fwd_en   = 1'b1;
        fwd_data = wr1_data;
      end
    end
`else
    assign fwd_en   = 1'b0;
    assign fwd_data = '0;
`endif
    register_file_mp_rd_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_VALUE(RESET_VALUE),
      .ZERO_REG   (ZERO_REG)
    ) u_lane (
      .idx     (lane_idx[k]),
      .run     (run),
      .regs    (regs),
      .fwd_en  (fwd_en),
      .fwd_data(fwd_data),
      .data    (lane_data[k])
    );
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp (default parameters, 2 read ports, DEBUG_INDEX=2).
module tb_register_file_mp;
  localparam logic [31:0] RV = 32'hFFFF_FF91;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  read_index;
  logic [63:0] read_data;
  logic [1:0]  read_pending;
  logic        wr0_enable, wr1_enable, reserve_enable;
  logic [4:0]  wr0_index, wr1_index, reserve_index;
  logic [31:0] wr0_data, wr1_data;
  logic        ready;
  logic [31:0] debug_reg;

  int n_cmp = 0;
  int n_bad = 0;

  register_file_mp dut (
    .clk(clk), .reset_n(reset_n),
    .read_index(read_index), .read_data(read_data), .read_pending(read_pending),
    .wr0_enable(wr0_enable), .wr0_index(wr0_index), .wr0_data(wr0_data),
    .wr1_enable(wr1_enable), .wr1_index(wr1_index), .wr1_data(wr1_data),
    .reserve_enable(reserve_enable), .reserve_index(reserve_index),
    .ready(ready), .debug_reg(debug_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    wr0_enable = 1'b0; wr1_enable = 1'b0; reserve_enable = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    read_index = {a1, a0}; #1;
  endtask

  task automatic w0(input logic [4:0] i, input logic [31:0] d);
    wr0_enable = 1'b1; wr0_index = i; wr0_data = d;
  endtask

  task automatic w1(input logic [4:0] i, input logic [31:0] d);
    wr1_enable = 1'b1; wr1_index = i; wr1_data = d;
  endtask

  task automatic rsv(input logic [4:0] i);
    reserve_enable = 1'b1; reserve_index = i;
  endtask

  // Released between edges; 32 sweep edges keep ready low, then ready rises.
  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      if (i == 0 || i == 31) chk({tag, "_ready_lo"}, {31'd0, ready}, 32'd0);
      tick();
    end
    chk({tag, "_ready_hi"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; read_index = '0;
    wr0_enable = 0; wr1_enable = 0; reserve_enable = 0;
    wr0_index = 0; wr1_index = 0; reserve_index = 0; wr0_data = 0; wr1_data = 0;
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_pend", {30'd0, read_pending}, 32'd0);
    reset_n = 1'b1;
    // INIT: write and reserve are ignored, reads give the sweep value
    w0(5'd5, 32'h1234); rsv(5'd5);
    rd(5'd1, 5'd0);
    chk("init_r1", read_data[31:0], RV);
    chk("init_r0", read_data[63:32], 32'd0);
    chk("init_dbg", debug_reg, RV);
    sweep("init");

    rd(5'd1, 5'd17);
    chk("run_r1", read_data[31:0], RV);
    chk("run_r17", read_data[63:32], RV);
    rd(5'd31, 5'd0);
    chk("run_r31", read_data[31:0], RV);
    chk("run_r0", read_data[63:32], 32'd0);
    rd(5'd5, 5'd5);
    chk("init_wr_dropped", read_data[31:0], RV);
    chk("init_rsv_dropped", {30'd0, read_pending}, 32'd0);

    w0(5'd5, 32'h1234); tick();
    rd(5'd5, 5'd5);
    chk("wr0_p0", read_data[31:0], 32'h1234);
    chk("wr0_p1", read_data[63:32], 32'h1234);
    w0(5'd0, 32'hFFFF); tick();
    rd(5'd0, 5'd5);
    chk("zero_reg", read_data[31:0], 32'd0);

    w0(5'd7, 32'hA); w1(5'd7, 32'hB); tick();
    rd(5'd7, 5'd7);
    chk("wr1_wins", read_data[31:0], 32'hB);
    w0(5'd8, 32'h1); w1(5'd9, 32'h2); tick();
    rd(5'd8, 5'd9);
    chk("dual_r8", read_data[31:0], 32'h1);
    chk("dual_r9", read_data[63:32], 32'h2);

    // scoreboard
    rsv(5'd9); tick();
    rd(5'd8, 5'd9);
    chk("rsv_pend", {30'd0, read_pending}, 32'b10);
    w0(5'd9, 32'h3); tick();
    chk("wr0_keeps_pend", {30'd0, read_pending}, 32'b10);
    chk("wr0_r9", read_data[63:32], 32'h3);
    w1(5'd9, 32'h55);
    chk("pend_no_bypass", {30'd0, read_pending}, 32'b10);
    tick();
    chk("wr1_clears", {30'd0, read_pending}, 32'b00);
    chk("wr1_r9", read_data[63:32], 32'h55);
    rsv(5'd9); w1(5'd9, 32'h66); tick();
    chk("rsv_wins", {30'd0, read_pending}, 32'b10);
    chk("rsv_wr1_r9", read_data[63:32], 32'h66);
    rsv(5'd9); tick();
    chk("rsv_again", {30'd0, read_pending}, 32'b10);
    rsv(5'd0); tick();
    rd(5'd0, 5'd9);
    chk("rsv_r0_ignored", {30'd0, read_pending}, 32'b10);

    // bypass / debug_reg
    w0(5'd3, 32'h11); w1(5'd2, 32'hC0DE); tick();
    chk("dbg_r2", debug_reg, 32'hC0DE);
    rd(5'd3, 5'd3);
    w0(5'd3, 32'hDEADBEEF); #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same_cycle", read_data[31:0], 32'hDEADBEEF);
`else
    chk("byp_same_cycle", read_data[31:0], 32'h11);
`endif
    tick();
    chk("byp_next_cycle", read_data[63:32], 32'hDEADBEEF);
    w0(5'd2, 32'h5); w1(5'd2, 32'h6); #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_dbg_wr1", debug_reg, 32'h6);
`else
    chk("byp_dbg_wr1", debug_reg, 32'hC0DE);
`endif
    tick();
    chk("dbg_after", debug_reg, 32'h6);

    // mid-run reset
    w0(5'd4, 32'h77); rsv(5'd4); tick();
    rd(5'd4, 5'd9);
    chk("mid_pre_data", read_data[31:0], 32'h77);
    chk("mid_pre_pend", {30'd0, read_pending}, 32'b11);
    #2 reset_n = 1'b0; #1;
    chk("mid_ready", {31'd0, ready}, 32'd0);
    chk("mid_pend", {30'd0, read_pending}, 32'd0);
    chk("mid_r4", read_data[31:0], RV);
    w0(5'd4, 32'h99);
    tick();
    reset_n = 1'b1;
    sweep("mid");
    rd(5'd4, 5'd9);
    chk("mid_post_r4", read_data[31:0], RV);
    chk("mid_post_r9", read_data[63:32], RV);
    chk("mid_post_pend", {30'd0, read_pending}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
